// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and constants for the divider issue stage.
//            Holds the issue FSM state encoding, the datapath width and the
//            special operand/result values used for exception handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_W = 16;

  // Two's-complement corner values for the divider datapath
  localparam logic [DIV_W-1:0] INT_MIN   = 16'h8000;
  localparam logic [DIV_W-1:0] NEG_ONE   = 16'hFFFF;
  localparam logic [DIV_W-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/signed_div.sv
// ============================================================================
// Module   : signed_div
// Purpose  : Combinational 16-bit signed divider. Quotient truncates toward
//            zero; remainder takes the sign of the dividend.
//            Division by zero and INT_MIN / -1 produce defined but
//            meaningless values; the issue stage overrides both.
// Ports    : dividend  - two's-complement dividend
//            divisor   - two's-complement divisor
//            quotient  - signed quotient
//            remainder - signed remainder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_div
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  logic             a_neg;
  logic             b_neg;
  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;
  logic [DIV_W-1:0] b_safe;
  logic [DIV_W-1:0] q_mag;
  logic [DIV_W-1:0] r_mag;

  // Divide magnitudes unsigned, then restore signs. The magnitude of
  // INT_MIN is 16'h8000, which is still representable as unsigned.
  always_comb begin
    a_neg     = dividend[DIV_W-1];
    b_neg     = divisor[DIV_W-1];
    a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
    // Keep the operator total so simulation never sees X on divide-by-zero
    b_safe    = (b_mag == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quotient  = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    remainder = a_neg ? (~r_mag + 1'b1) : r_mag;
  end

endmodule : signed_div

`default_nettype wire

// File: rtl/div_issue_stage.sv
// ============================================================================
// Module   : div_issue_stage
// Purpose  : Issue/capture stage around the combinational signed_div.
//            Registers an operand pair on accept, waits SETTLE_CYCLES for the
//            multicycle divider path, captures quotient/remainder with
//            exception flags, and holds the result until drained.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready, in_dividend, in_divisor   - operand handshake
//            out_valid/out_ready, out_quotient, out_remainder,
//            out_div_zero, out_overflow                   - result handshake
//            busy                                         - state != IDLE
// Config   : DIV_ISSUE_OVERLAP_EN - when defined, a new operand pair may be
//            accepted on the same edge the current result drains.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_issue_stage
  import div_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] in_dividend,
  input  logic [DIV_W-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] out_quotient,
  output logic [DIV_W-1:0] out_remainder,
  output logic             out_div_zero,
  output logic             out_overflow,
  output logic             busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [DIV_W-1:0] op_a;
  logic [DIV_W-1:0] op_b;
  logic [DIV_W-1:0] div_quot;
  logic [DIV_W-1:0] div_rem;
  logic             accept;
  logic             in_div_zero;
  logic             in_overflow;

  // Divider sees only the registered operands, so it is stable while settling
  signed_div u_signed_div (
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

`ifdef DIV_ISSUE_OVERLAP_EN
  assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
`else
  assign in_ready = ~rst & (state == IDLE);
`endif

  assign accept      = in_valid & in_ready;
  assign busy        = (state != IDLE);
  assign in_div_zero = (in_divisor == '0);
  assign in_overflow = (in_dividend == INT_MIN) & (in_divisor == NEG_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      op_a          <= '0;
      op_b          <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (settle_cnt == '0) begin
            state         <= DONE;
            out_valid     <= 1'b1;
            out_quotient  <= div_quot;
            out_remainder <= div_rem;
            out_div_zero  <= 1'b0;
            out_overflow  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // Placed after the case so an overlapped accept in DONE overrides
      // the drain's move to IDLE.
      if (accept) begin
        op_a <= in_dividend;
        op_b <= in_divisor;
        if (in_div_zero) begin
          state         <= DONE;
          out_valid     <= 1'b1;
          out_quotient  <= DIV0_QUOT;
          out_remainder <= in_dividend;
          out_div_zero  <= 1'b1;
          out_overflow  <= 1'b0;
        end else if (in_overflow) begin
          state         <= DONE;
          out_valid     <= 1'b1;
          out_quotient  <= INT_MIN;
          out_remainder <= '0;
          out_div_zero  <= 1'b0;
          out_overflow  <= 1'b1;
        end else begin
          state      <= WAIT;
          settle_cnt <= SETTLE_LOAD;
        end
      end
    end
  end

endmodule : div_issue_stage

`default_nettype wire

// File: tb/tb_div_issue_stage.sv
// ============================================================================
// Module   : tb_div_issue_stage
// Purpose  : Directed self-checking bench for div_issue_stage with
//            SETTLE_CYCLES = 2. Inputs change and outputs are sampled 1 ns
//            after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dividend;
  logic [15:0] in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quotient;
  logic [15:0] out_remainder;
  logic        out_div_zero;
  logic        out_overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_issue_stage #(.SETTLE_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero),
    .out_overflow  (out_overflow),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair for one edge; the pair must be accepted there.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    #1;
    chk("issue_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    in_valid    = 1'b0;
    in_dividend = 16'hDEAD;
    in_divisor  = 16'hBEEF;
  endtask

  task automatic chk_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                            input logic dz, input logic ov);
    chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_quot"}, out_quotient, q);
    chk({tag, "_rem"}, out_remainder, r);
    chk({tag, "_flags"}, {14'd0, out_div_zero, out_overflow}, {14'd0, dz, ov});
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;

    // Reset state
    step();
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_quot", out_quotient, 16'd0);
    chk("rst_rem", out_remainder, 16'd0);
    chk("rst_flags", {14'd0, out_div_zero, out_overflow}, 16'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

    // 100 / 7, with an ignored request while busy
    issue(16'd100, 16'd7);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    chk("t1_in_ready", {15'd0, in_ready}, 16'd0);
    chk("t1_valid_e0", {15'd0, out_valid}, 16'd0);
    in_valid = 1'b1; in_dividend = 16'd5; in_divisor = 16'd5;
    step();
    in_valid = 1'b0;
    chk("t1_valid_e1", {15'd0, out_valid}, 16'd0);
    step();
    chk_result("t1", 16'd14, 16'd2, 1'b0, 1'b0);
`ifndef DIV_ISSUE_OVERLAP_EN
    chk("t1_done_in_ready", {15'd0, in_ready}, 16'd0);
`endif
    step();
    chk("t1_drained", {15'd0, out_valid}, 16'd0);
    chk("t1_idle_ready", {15'd0, in_ready}, 16'd1);
    chk("t1_idle_busy", {15'd0, busy}, 16'd0);

    // -100 / 7 held under back-pressure
    out_ready = 1'b0;
    issue(16'hFF9C, 16'd7);
    step();
    step();
    chk_result("t2", 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", {15'd0, out_valid}, 16'd1);
      chk("t2_hold_quot", out_quotient, 16'hFFF2);
      chk("t2_hold_rem", out_remainder, 16'hFFFE);
    end
    out_ready = 1'b1;
    step();
    chk("t2_drained", {15'd0, out_valid}, 16'd0);

    // 7 / -2 -> -3 rem 1
    issue(16'd7, 16'hFFFE);
    step();
    step();
    chk_result("t2b", 16'hFFFD, 16'd1, 1'b0, 1'b0);
    step();

    // 1234 / 0
    issue(16'd1234, 16'd0);
    chk_result("t3", 16'hFFFF, 16'd1234, 1'b1, 1'b0);
    step();
    chk("t3_drained", {15'd0, out_valid}, 16'd0);

    // INT_MIN / -1
    issue(16'h8000, 16'hFFFF);
    chk_result("t4", 16'h8000, 16'h0000, 1'b0, 1'b1);
    step();
    chk("t4_drained", {15'd0, out_valid}, 16'd0);

    // Reset during WAIT abandons 50 / 5
    issue(16'd50, 16'd5);
    chk("t5_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", {15'd0, in_ready}, 16'd0);
    step();
    chk("t5_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("t5_rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    #1;
    chk("t5_ready_after_rst", {15'd0, in_ready}, 16'd1);
    step();
    step();
    chk("t5_no_valid", {15'd0, out_valid}, 16'd0);
    issue(16'd9, 16'd3);
    step();
    step();
    chk_result("t5", 16'd3, 16'd0, 1'b0, 1'b0);
    step();

`ifdef DIV_ISSUE_OVERLAP_EN
    // Drain 20 / 3 while accepting 21 / 4 on the same edge
    issue(16'd20, 16'd3);
    step();
    step();
    chk_result("t6a", 16'd6, 16'd2, 1'b0, 1'b0);
    issue(16'd21, 16'd4);
    chk("t6_overlap_valid", {15'd0, out_valid}, 16'd0);
    chk("t6_overlap_busy", {15'd0, busy}, 16'd1);
    step();
    chk("t6_valid_e1", {15'd0, out_valid}, 16'd0);
    step();
    chk_result("t6b", 16'd5, 16'd1, 1'b0, 1'b0);
    // DONE -> DONE with an exception pair
    issue(16'd5, 16'd0);
    chk_result("t6c", 16'hFFFF, 16'd5, 1'b1, 1'b0);
    step();
    chk("t6_drained", {15'd0, out_valid}, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_issue_stage

`default_nettype wire
